// File: rtl/axil_cfg_master.sv
// AXI-Lite initiator: converts a valid/ready register-command stream into single
// AXI-Lite write/read transactions, one outstanding, with a per-handshake timeout.
module axil_cfg_master #(
  parameter int                         AXIL_ADDR_WIDTH = 40,
  parameter int                         AXIL_WIDTH      = 32,
  parameter int                         STRB_WIDTH      = AXIL_WIDTH / 8,
  parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR  = '0,
  parameter int                         TIMEOUT_CYC     = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  // command stream
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXIL_WIDTH-1:0]      cmd_wdata,
  input  logic [STRB_WIDTH-1:0]      cmd_wstrb,
  // response stream
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_we,
  output logic [AXIL_WIDTH-1:0]      rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       rsp_timeout,
  // AXI-Lite write address
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  // AXI-Lite write data
  output logic [AXIL_WIDTH-1:0]      m_axil_wdata,
  output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  // AXI-Lite write response
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  // AXI-Lite read address
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  // AXI-Lite read data
  input  logic [AXIL_WIDTH-1:0]      m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                     state_reg, state_next;
  logic                       cmd_ready_reg, cmd_ready_next;
  logic                       awvalid_reg, awvalid_next;
  logic                       wvalid_reg, wvalid_next;
  logic                       bready_reg, bready_next;
  logic                       arvalid_reg, arvalid_next;
  logic                       rready_reg, rready_next;
  logic                       rsp_valid_reg, rsp_valid_next;
  logic                       rsp_we_reg, rsp_we_next;
  logic [AXIL_WIDTH-1:0]      rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]                 rsp_resp_reg, rsp_resp_next;
  logic                       rsp_timeout_reg, rsp_timeout_next;
  logic [AXIL_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [AXIL_WIDTH-1:0]      wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0]      wstrb_reg, wstrb_next;
  logic [TW-1:0]              timer_reg, timer_next;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic timeout_hit;
  logic abort;

  assign aw_hs = awvalid_reg && m_axil_awready;
  assign w_hs  = wvalid_reg && m_axil_wready;
  assign b_hs  = bready_reg && m_axil_bvalid;
  assign ar_hs = arvalid_reg && m_axil_arready;
  assign r_hs  = rready_reg && m_axil_rvalid;

  // A zero TIMEOUT_CYC leaves the timer free-running but never firing.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_reg == TIMER_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      cmd_ready_reg   <= 1'b0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_we_reg      <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= 2'b00;
      rsp_timeout_reg <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      timer_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      cmd_ready_reg   <= cmd_ready_next;
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      bready_reg      <= bready_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_we_reg      <= rsp_we_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_resp_reg    <= rsp_resp_next;
      rsp_timeout_reg <= rsp_timeout_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      wstrb_reg       <= wstrb_next;
      timer_reg       <= timer_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cmd_ready_next   = 1'b0;
    awvalid_next     = awvalid_reg;
    wvalid_next      = wvalid_reg;
    bready_next      = bready_reg;
    arvalid_next     = arvalid_reg;
    rready_next      = rready_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_we_next      = rsp_we_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_resp_next    = rsp_resp_reg;
    rsp_timeout_next = rsp_timeout_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    wstrb_next       = wstrb_reg;
    timer_next       = timer_reg + 1'b1;
    abort            = 1'b0;

    case (state_reg)
      IDLE: begin
        timer_next     = '0;
        cmd_ready_next = 1'b1;
        if (cmd_valid && cmd_ready_reg) begin
          cmd_ready_next   = 1'b0;
          addr_next        = cmd_addr + AXIL_BASE_ADDR;
          wdata_next       = cmd_wdata;
          wstrb_next       = cmd_wstrb;
          rsp_we_next      = cmd_we;
          rsp_rdata_next   = '0;
          rsp_resp_next    = 2'b00;
          rsp_timeout_next = 1'b0;
          if (cmd_we) begin
            state_next   = WR_ADDR_DATA;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RD_ADDR;
            arvalid_next = 1'b1;
          end
        end
      end

      WR_ADDR_DATA: begin
        if (aw_hs) awvalid_next = 1'b0;
        if (w_hs)  wvalid_next  = 1'b0;
        // Any progress on either channel restarts the wait.
        if (aw_hs || w_hs) timer_next = '0;
        else if (timeout_hit) abort = 1'b1;
        if (!abort && !awvalid_next && !wvalid_next) begin
          state_next  = WR_RESP;
          bready_next = 1'b1;
          timer_next  = '0;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          rsp_resp_next  = m_axil_bresp;
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
          timer_next     = '0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
          timer_next   = '0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      RD_DATA: begin
        if (r_hs) begin
          rsp_rdata_next = m_axil_rdata;
          rsp_resp_next  = m_axil_rresp;
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
          timer_next     = '0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      RESP: begin
        timer_next = '0;
        if (rsp_valid_reg && rsp_ready) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    // Abort drops every AXI valid/ready so late B/R beats are simply ignored.
    if (abort) begin
      awvalid_next     = 1'b0;
      wvalid_next      = 1'b0;
      bready_next      = 1'b0;
      arvalid_next     = 1'b0;
      rready_next      = 1'b0;
      rsp_valid_next   = 1'b1;
      rsp_timeout_next = 1'b1;
      rsp_resp_next    = 2'b10;
      rsp_rdata_next   = '0;
      state_next       = RESP;
      timer_next       = '0;
    end
  end

  assign cmd_ready      = cmd_ready_reg;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_we         = rsp_we_reg;
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_resp       = rsp_resp_reg;
  assign rsp_timeout    = rsp_timeout_reg;

  assign m_axil_awaddr  = addr_reg;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_reg;
  assign m_axil_wdata   = wdata_reg;
  assign m_axil_wstrb   = wstrb_reg;
  assign m_axil_wvalid  = wvalid_reg;
  assign m_axil_bready  = bready_reg;
  assign m_axil_araddr  = addr_reg;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_reg;
  assign m_axil_rready  = rready_reg;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: directed commands against a stallable AXI-Lite slave
// model, with a response scoreboard checked by an independent monitor.
module tb_axil_cfg_master;

  localparam int AW = 40;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam logic [AW-1:0] BASE = 40'h12_0000_1000;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [SW-1:0] m_axil_wstrb;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;

  axil_cfg_master #(
    .AXIL_ADDR_WIDTH(AW), .AXIL_WIDTH(DW), .STRB_WIDTH(SW),
    .AXIL_BASE_ADDR(BASE), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rsp_t          sb_q[$];
  logic [AW-1:0] aw_exp_q[$];
  logic [AW-1:0] ar_exp_q[$];
  logic [35:0]   w_exp_q[$];

  // slave controls, written by the stimulus process
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit         ar_never = 1'b0;
  bit         rand_mode = 1'b0;
  logic [1:0] slv_bresp = 2'b00, slv_rresp = 2'b00;
  int         b_fires = 0, r_fires = 0, exp_b = 0, exp_r = 0;
  int         ar_hi = 0, ar_hi_last = 0;
  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int sidx(input logic [AW-1:0] a);
    logic [AW-1:0] off = a - BASE;
    return int'(off[5:2]);
  endfunction

  function automatic rsp_t mk(input logic we, input logic [31:0] d, input logic [1:0] r,
                              input logic t);
    rsp_t x;
    x.we = we; x.rdata = d; x.resp = r; x.to = t;
    return x;
  endfunction

  // AXI-Lite slave model: ready/valid changes on the falling edge only
  initial begin
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0, b_pend = 0, r_pend = 0, ar_wait = 0;
    logic [AW-1:0] cap_aw = '0, cap_ar = '0;
    logic [31:0]   cap_wd = '0;
    logic [3:0]    cap_ws = '0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
    m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
    for (int i = 0; i < 16; i++) smem[i] = 32'h0;
    smem[1] = 32'h12345678;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0; ar_wait = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; ar_hi = 0;
        continue;
      end
      // AW
      if (m_axil_awready) begin
        m_axil_awready = 0; aw_got = 1; aw_cnt = 0;
        if (rand_mode) aw_delay = $urandom_range(0, 3);
      end else if (m_axil_awvalid && !aw_got) begin
        if (aw_cnt >= aw_delay) begin
          m_axil_awready = 1; cap_aw = m_axil_awaddr;
          if (aw_exp_q.size() == 0) chk("aw_unexpected", 1, 0);
          else chk("awaddr", {m_axil_awprot, m_axil_awaddr}, {3'b000, aw_exp_q.pop_front()});
        end else aw_cnt++;
      end
      // W
      if (m_axil_wready) begin
        m_axil_wready = 0; w_got = 1; w_cnt = 0;
        if (rand_mode) w_delay = $urandom_range(0, 3);
      end else if (m_axil_wvalid && !w_got) begin
        if (w_cnt >= w_delay) begin
          m_axil_wready = 1; cap_wd = m_axil_wdata; cap_ws = m_axil_wstrb;
          if (w_exp_q.size() == 0) chk("w_unexpected", 1, 0);
          else chk("wdata_wstrb", {m_axil_wdata, m_axil_wstrb}, w_exp_q.pop_front());
        end else w_cnt++;
      end
      // AR, with a check that arvalid holds through a stall
      if (ar_wait && !ar_never) chk("ar_hold", m_axil_arvalid, 1);
      if (m_axil_arready) begin
        m_axil_arready = 0; ar_got = 1; ar_cnt = 0; ar_hi = 0;
        if (rand_mode) ar_delay = $urandom_range(0, 3);
      end else if (m_axil_arvalid && !ar_got) begin
        ar_hi++;
        if (!ar_never && ar_cnt >= ar_delay) begin
          m_axil_arready = 1; cap_ar = m_axil_araddr;
          if (ar_exp_q.size() == 0) chk("ar_unexpected", 1, 0);
          else chk("araddr", {m_axil_arprot, m_axil_araddr}, {3'b000, ar_exp_q.pop_front()});
        end else ar_cnt++;
      end else if (ar_hi != 0) begin
        ar_hi_last = ar_hi; ar_hi = 0; ar_cnt = 0;
      end
      ar_wait = m_axil_arvalid && !m_axil_arready;
      // B
      if (m_axil_bvalid && b_pend) begin
        m_axil_bvalid = 0; b_pend = 0; b_fires++; aw_got = 0; w_got = 0; b_cnt = 0;
        if (rand_mode) b_delay = $urandom_range(0, 3);
      end else if (aw_got && w_got && !m_axil_bvalid) begin
        if (b_cnt >= b_delay) begin
          smem[sidx(cap_aw)] = merge(smem[sidx(cap_aw)], cap_wd, cap_ws);
          m_axil_bvalid = 1; m_axil_bresp = slv_bresp;
        end else b_cnt++;
      end
      if (m_axil_bvalid && m_axil_bready) b_pend = 1;
      // R
      if (m_axil_rvalid && r_pend) begin
        m_axil_rvalid = 0; r_pend = 0; r_fires++; ar_got = 0; r_cnt = 0;
        if (rand_mode) r_delay = $urandom_range(0, 3);
      end else if (ar_got && !m_axil_rvalid) begin
        if (r_cnt >= r_delay) begin
          m_axil_rvalid = 1; m_axil_rdata = smem[sidx(cap_ar)]; m_axil_rresp = slv_rresp;
        end else r_cnt++;
      end
      if (m_axil_rvalid && m_axil_rready) r_pend = 1;
    end
  end

  // response monitor: drives rsp_ready, pops and compares on each handshake
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rsp_ready = 1'b0;
        continue;
      end
      rsp_ready = rand_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        $display("rsp we=%0b rdata=%08h resp=%0b timeout=%0b", rsp_we, rsp_rdata, rsp_resp,
                 rsp_timeout);
        if (sb_q.size() == 0) chk("rsp_extra", 1, 0);
        else chk("rsp", {rsp_we, rsp_rdata, rsp_resp, rsp_timeout}, sb_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [AW-1:0] axi_addr,
                          input rsp_t exp, input bit axi, output int acc);
    int n = 0;
    sb_q.push_back(exp);
    if (axi) begin
      if (we) begin
        aw_exp_q.push_back(axi_addr); w_exp_q.push_back({wd, ws}); exp_b++;
      end else begin
        ar_exp_q.push_back(axi_addr); exp_r++;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    chk("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, n;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                      m_axil_rready, rsp_valid, rsp_we, rsp_timeout, rsp_resp}, 0);
    chk("reset_data", {rsp_rdata, m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_wstrb,
                       m_axil_awprot, m_axil_arprot}, 0);
    rstn = 1'b1;
    #1 chk("release_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("release_cmd_ready_high", cmd_ready, 1);

    // zero-wait write
    send_cmd(1, 40'h10, 32'hDEADBEEF, 4'hF, 40'h12_0000_1010, mk(1, 0, 2'b00, 0), 1, a0);
    wait_idle();
    // read with stalled arready and rvalid
    ar_delay = 2; r_delay = 3;
    send_cmd(0, 40'h04, 0, 0, 40'h12_0000_1004, mk(0, 32'h12345678, 2'b00, 0), 1, a0);
    wait_idle();
    ar_delay = 0; r_delay = 0;
    // W completes well before AW, then both together, then read back the merge
    aw_delay = 5;
    send_cmd(1, 40'h08, 32'hCAFEF00D, 4'h3, 40'h12_0000_1008, mk(1, 0, 2'b00, 0), 1, a0);
    wait_idle();
    aw_delay = 0;
    send_cmd(1, 40'h08, 32'h11223344, 4'hC, 40'h12_0000_1008, mk(1, 0, 2'b00, 0), 1, a0);
    wait_idle();
    send_cmd(0, 40'h08, 0, 0, 40'h12_0000_1008, mk(0, 32'h1122F00D, 2'b00, 0), 1, a0);
    wait_idle();
    // back-to-back zero-wait writes: 4 cycles between acceptances
    send_cmd(1, 40'h0C, 32'h1, 4'hF, 40'h12_0000_100C, mk(1, 0, 2'b00, 0), 1, a0);
    send_cmd(1, 40'h0C, 32'h2, 4'hF, 40'h12_0000_100C, mk(1, 0, 2'b00, 0), 1, a1);
    chk("wr_throughput", a1 - a0, 4);
    wait_idle();
    // slave error passes through
    slv_rresp = 2'b10;
    send_cmd(0, 40'h10, 0, 0, 40'h12_0000_1010, mk(0, 32'hDEADBEEF, 2'b10, 0), 1, a0);
    wait_idle();
    slv_rresp = 2'b00;
    // arready never comes: abort after TO cycles
    ar_never = 1'b1;
    send_cmd(0, 40'h00, 0, 0, 40'h0, mk(0, 0, 2'b10, 1), 0, a0);
    wait_idle();
    chk("timeout_arvalid_cycles", ar_hi_last, TO);
    chk("timeout_arvalid_low", m_axil_arvalid, 0);
    ar_never = 1'b0;
    send_cmd(0, 40'h0C, 0, 0, 40'h12_0000_100C, mk(0, 32'h2, 2'b00, 0), 1, a0);
    wait_idle();

    // reset while waiting for B: transaction abandoned, no response
    b_delay = 10;
    send_cmd(1, 40'h1C, 32'hA5A5A5A5, 4'hF, 40'h12_0000_101C, mk(1, 0, 2'b00, 0), 1, a0);
    n = 0;
    while (!m_axil_bready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_resp", m_axil_bready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    exp_b--;
    #1 chk("midreset_ctl", {cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                            m_axil_arvalid, m_axil_rready, rsp_valid}, 0);
    repeat (3) @(negedge clk);
    b_delay = 0;
    rstn = 1'b1;
    #1 chk("midreset_release_low", cmd_ready, 0);
    @(negedge clk);
    chk("midreset_release_high", cmd_ready, 1);
    send_cmd(0, 40'h1C, 0, 0, 40'h12_0000_101C, mk(0, 32'h0, 2'b00, 0), 1, a0);
    wait_idle();

    // random traffic over words 8..15 with stalls everywhere
    rand_mode = 1'b1;
    aw_delay = 1; w_delay = 2; b_delay = 1; ar_delay = 3; r_delay = 2;
    for (int i = 0; i < 200; i++) begin
      bit          we = 1'($urandom_range(0, 1));
      int          idx = $urandom_range(8, 15);
      logic [AW-1:0] off = AW'(idx * 4);
      logic [31:0] wd = $urandom;
      logic [3:0]  ws = 4'($urandom_range(1, 15));
      rsp_t        e;
      if (we) begin
        ref_mem[idx] = merge(ref_mem[idx], wd, ws);
        e = mk(1, 0, 2'b00, 0);
      end else begin
        e = mk(0, ref_mem[idx], 2'b00, 0);
      end
      send_cmd(we, off, wd, ws, BASE + off, e, 1, a0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_handshakes", b_fires, exp_b);
    chk("r_handshakes", r_fires, exp_r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "global time limit");
  end

endmodule
